// File: rtl/rdma_track_wr_sched_if.sv
// WQE issue and completion handshake between the track write scheduler and the ERNIC.
interface rdma_track_wr_sched_if;
    logic        wqe_valid;
    logic        wqe_ready;
    logic [3:0]  wqe_qpn;
    logic [63:0] wqe_laddr;
    logic [63:0] wqe_raddr;
    logic [31:0] wqe_rkey;
    logic [31:0] wqe_len;
    logic        cq_valid;
    logic [3:0]  cq_qpn;
    logic [7:0]  cq_status;

    modport master (
        output wqe_valid, wqe_qpn, wqe_laddr, wqe_raddr, wqe_rkey, wqe_len,
        input  wqe_ready, cq_valid, cq_qpn, cq_status
    );

    modport slave (
        input  wqe_valid, wqe_qpn, wqe_laddr, wqe_raddr, wqe_rkey, wqe_len,
        output wqe_ready, cq_valid, cq_qpn, cq_status
    );
endinterface

// File: rtl/rdma_track_wr_sched.sv
// Per-QP MR table and one-track-at-a-time RDMA WRITE scheduler: issues a WQE per
// RDMA_write_en, waits for its completion and reports RDMA_track_done to the connection FSM.
module rdma_track_wr_sched #(
    parameter int unsigned QP_NUM     = 9,
    parameter logic [63:0] LOCAL_BASE = 64'h0,
    parameter logic [31:0] LOCAL_SIZE = 32'h4000_0000,
    parameter logic [23:0] CQ_TIMEOUT = 24'hFF_FFFF
) (
    input  logic                          core_clk,
    input  logic                          core_aresetn,
    input  logic                          rx_MR_tvalid,
    input  logic [3:0]                    rx_MR_QPn,
    input  logic [63:0]                   host_MR_addr,
    input  logic [31:0]                   host_MR_len,
    input  logic [31:0]                   host_MR_rkey,
    input  logic [3:0]                    IMC_NUM,
    input  logic [3:0]                    track_num_per_IMC,
    input  logic [31:0]                   track_len,
    input  logic                          RDMA_write_en,
    rdma_track_wr_sched_if.master         wqe_if,
    output logic                          RDMA_track_done,
    output logic                          track_tlast,
    output logic [3:0]                    cur_qpn,
    output logic                          wr_error
);

    localparam int unsigned DEPTH   = QP_NUM - 1;
    localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned MAX_QPN = QP_NUM - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_CQ,
        S_DONE,
        S_ERR
    } state_t;

    state_t      r_state;
    logic [63:0] r_mr_addr [DEPTH];
    logic [31:0] r_mr_len  [DEPTH];
    logic [31:0] r_mr_rkey [DEPTH];
    logic [63:0] r_roff    [DEPTH];
    logic [63:0] r_loff;
    logic [3:0]  r_cur_qpn;
    logic [3:0]  r_trk_cnt;
    logic [23:0] r_to_cnt;
    logic        r_wqe_valid;
    logic [3:0]  r_wqe_qpn;
    logic [63:0] r_wqe_laddr;
    logic [63:0] r_wqe_raddr;
    logic [31:0] r_wqe_rkey;
    logic [31:0] r_wqe_len;
    logic        r_done;
    logic        r_tlast;
    logic        r_err;

    logic [IDX_W-1:0] w_cur_idx;
    logic [IDX_W-1:0] w_wqe_idx;
    logic [IDX_W-1:0] w_rx_idx;
    logic             w_rx_hit;
    logic [3:0]       w_imc_eff;
    logic [3:0]       w_tpi_eff;
    logic             w_last_qp;
    logic             w_last_trk;
    logic             w_cq_ok;
    logic [63:0]      w_len_x2;
    logic [63:0]      w_roff_next2;
    logic [63:0]      w_loff_next2;

    // Table indices are QP number minus 2 (QP0/QP1 carry no data)
    assign w_cur_idx  = IDX_W'(r_cur_qpn - 4'd2);
    assign w_wqe_idx  = IDX_W'(r_wqe_qpn - 4'd2);
    assign w_rx_idx   = IDX_W'(rx_MR_QPn - 4'd2);
    assign w_rx_hit   = rx_MR_tvalid && (rx_MR_QPn >= 4'd2) && (32'(rx_MR_QPn) <= MAX_QPN);

    assign w_imc_eff  = (IMC_NUM == 4'd0) ? 4'd1 : IMC_NUM;
    assign w_tpi_eff  = (track_num_per_IMC == 4'd0) ? 4'd1 : track_num_per_IMC;
    // Also wrap at the top of the table so an oversized IMC_NUM cannot index past it
    assign w_last_qp  = (32'(r_cur_qpn) >= 32'(w_imc_eff) + 32'd1) || (32'(r_cur_qpn) >= MAX_QPN);
    assign w_last_trk = (r_trk_cnt >= w_tpi_eff - 4'd1);
    assign w_cq_ok    = (wqe_if.cq_qpn == r_wqe_qpn) && (wqe_if.cq_status == 8'd0);

    // Wrap test looks one track ahead: restart once the next track would not fit
    assign w_len_x2     = {31'd0, r_wqe_len, 1'b0};
    assign w_roff_next2 = r_roff[w_wqe_idx] + w_len_x2;
    assign w_loff_next2 = r_loff + w_len_x2;

    always_ff @(posedge core_clk or negedge core_aresetn) begin
        if (!core_aresetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mr_addr[i] <= '0;
                r_mr_len[i]  <= '0;
                r_mr_rkey[i] <= '0;
                r_roff[i]    <= '0;
            end
            r_state     <= S_IDLE;
            r_loff      <= '0;
            r_cur_qpn   <= 4'd2;
            r_trk_cnt   <= '0;
            r_to_cnt    <= '0;
            r_wqe_valid <= 1'b0;
            r_wqe_qpn   <= '0;
            r_wqe_laddr <= '0;
            r_wqe_raddr <= '0;
            r_wqe_rkey  <= '0;
            r_wqe_len   <= '0;
            r_done      <= 1'b0;
            r_tlast     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_tlast <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (RDMA_write_en) begin
                        r_wqe_qpn   <= r_cur_qpn;
                        r_wqe_raddr <= r_mr_addr[w_cur_idx] + r_roff[w_cur_idx];
                        r_wqe_laddr <= LOCAL_BASE + r_loff;
                        r_wqe_rkey  <= r_mr_rkey[w_cur_idx];
                        r_wqe_len   <= track_len;
                        r_wqe_valid <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (wqe_if.wqe_ready) begin
                        r_wqe_valid <= 1'b0;
                        r_to_cnt    <= '0;
                        r_state     <= S_WAIT_CQ;
                    end
                end

                S_WAIT_CQ: begin
                    if (wqe_if.cq_valid) begin
                        if (w_cq_ok) begin
                            r_done  <= 1'b1;
                            r_tlast <= w_last_trk;
                            r_state <= S_DONE;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
                        end
                    end else if (r_to_cnt >= CQ_TIMEOUT - 24'd1) begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_to_cnt <= r_to_cnt + 24'd1;
                    end
                end

                S_DONE: begin
                    r_roff[w_wqe_idx] <= (w_roff_next2 > {32'd0, r_mr_len[w_wqe_idx]}) ?
                                         64'd0 : r_roff[w_wqe_idx] + {32'd0, r_wqe_len};
                    r_loff            <= (w_loff_next2 > {32'd0, LOCAL_SIZE}) ?
                                         64'd0 : r_loff + {32'd0, r_wqe_len};
                    if (w_last_trk) begin
                        r_trk_cnt <= '0;
                        r_cur_qpn <= w_last_qp ? 4'd2 : r_cur_qpn + 4'd1;
                    end else begin
                        r_trk_cnt <= r_trk_cnt + 4'd1;
                    end
                    r_state <= S_IDLE;
                end

                S_ERR: begin
                    r_state <= S_ERR;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // A fresh descriptor replaces the entry and restarts its remote offset
            if (w_rx_hit) begin
                r_mr_addr[w_rx_idx] <= host_MR_addr;
                r_mr_len[w_rx_idx]  <= host_MR_len;
                r_mr_rkey[w_rx_idx] <= host_MR_rkey;
                r_roff[w_rx_idx]    <= '0;
            end
        end
    end

    assign wqe_if.wqe_valid = r_wqe_valid;
    assign wqe_if.wqe_qpn   = r_wqe_qpn;
    assign wqe_if.wqe_laddr = r_wqe_laddr;
    assign wqe_if.wqe_raddr = r_wqe_raddr;
    assign wqe_if.wqe_rkey  = r_wqe_rkey;
    assign wqe_if.wqe_len   = r_wqe_len;
    assign RDMA_track_done  = r_done;
    assign track_tlast      = r_tlast;
    assign cur_qpn          = r_cur_qpn;
    assign wr_error         = r_err;

endmodule

// File: tb/tb_rdma_track_wr_sched.sv
// Scoreboard bench for rdma_track_wr_sched: directed tracks push expected WQEs and
// done/tlast pulses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_rdma_track_wr_sched;

    logic        core_clk = 1'b0;
    logic        core_aresetn;
    logic        rx_MR_tvalid;
    logic [3:0]  rx_MR_QPn;
    logic [63:0] host_MR_addr;
    logic [31:0] host_MR_len;
    logic [31:0] host_MR_rkey;
    logic [3:0]  IMC_NUM;
    logic [3:0]  track_num_per_IMC;
    logic [31:0] track_len;
    logic        RDMA_write_en;
    logic        RDMA_track_done;
    logic        track_tlast;
    logic [3:0]  cur_qpn;
    logic        wr_error;

    rdma_track_wr_sched_if wif();

    rdma_track_wr_sched #(
        .CQ_TIMEOUT (24'd16)
    ) dut (
        .core_clk          (core_clk),
        .core_aresetn      (core_aresetn),
        .rx_MR_tvalid      (rx_MR_tvalid),
        .rx_MR_QPn         (rx_MR_QPn),
        .host_MR_addr      (host_MR_addr),
        .host_MR_len       (host_MR_len),
        .host_MR_rkey      (host_MR_rkey),
        .IMC_NUM           (IMC_NUM),
        .track_num_per_IMC (track_num_per_IMC),
        .track_len         (track_len),
        .RDMA_write_en     (RDMA_write_en),
        .wqe_if            (wif),
        .RDMA_track_done   (RDMA_track_done),
        .track_tlast       (track_tlast),
        .cur_qpn           (cur_qpn),
        .wr_error          (wr_error)
    );

    always #5 core_clk = ~core_clk;

    typedef struct packed {
        logic [3:0]  qpn;
        logic [63:0] laddr;
        logic [63:0] raddr;
        logic [31:0] rkey;
        logic [31:0] len;
    } wqe_t;

    wqe_t exp_wqe_q[$];
    bit   exp_tlast_q[$];
    wqe_t mon_e;
    bit   mon_tlast;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every accepted WQE and every done pulse against the queues
    always @(negedge core_clk) begin
        if (core_aresetn) begin
            if (wif.wqe_valid && wif.wqe_ready) begin
                if (exp_wqe_q.size() == 0) begin
                    check("wqe_unexpected_qpn", 64'(wif.wqe_qpn), 64'hFFFF);
                end else begin
                    mon_e = exp_wqe_q.pop_front();
                    check("wqe_qpn",   64'(wif.wqe_qpn),  64'(mon_e.qpn));
                    check("wqe_laddr", wif.wqe_laddr,     mon_e.laddr);
                    check("wqe_raddr", wif.wqe_raddr,     mon_e.raddr);
                    check("wqe_rkey",  64'(wif.wqe_rkey), 64'(mon_e.rkey));
                    check("wqe_len",   64'(wif.wqe_len),  64'(mon_e.len));
                end
            end
            if (RDMA_track_done) begin
                done_cnt++;
                if (exp_tlast_q.size() == 0) begin
                    check("done_unexpected", 64'(RDMA_track_done), 64'd0);
                end else begin
                    mon_tlast = exp_tlast_q.pop_front();
                    check("track_tlast", 64'(track_tlast), 64'(mon_tlast));
                end
            end else if (track_tlast) begin
                check("tlast_without_done", 64'(track_tlast), 64'd0);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge core_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        core_aresetn = 1'b0;
        cyc(2);
        core_aresetn = 1'b1;
        cyc(1);
    endtask

    task automatic load_mr(input logic [3:0] qpn, input logic [63:0] addr,
                           input logic [31:0] len, input logic [31:0] rkey);
        rx_MR_tvalid = 1'b1;
        rx_MR_QPn    = qpn;
        host_MR_addr = addr;
        host_MR_len  = len;
        host_MR_rkey = rkey;
        cyc(1);
        rx_MR_tvalid = 1'b0;
    endtask

    task automatic set_cfg(input logic [3:0] imc, input logic [3:0] tpi);
        IMC_NUM           = imc;
        track_num_per_IMC = tpi;
        track_len         = 32'h1000;
    endtask

    // Pulse write_en, optionally stall wqe_ready, then accept the WQE
    task automatic issue_accept(input wqe_t e, input int stall);
        int n;
        exp_wqe_q.push_back(e);
        RDMA_write_en = 1'b1;
        cyc(1);
        RDMA_write_en = 1'b0;
        n = 0;
        while (!wif.wqe_valid && n < 20) begin
            cyc(1);
            n++;
        end
        check("wqe_valid_seen", 64'(wif.wqe_valid), 64'd1);
        for (int i = 0; i < stall; i++) begin
            check("stall_valid", 64'(wif.wqe_valid), 64'd1);
            check("stall_qpn",   64'(wif.wqe_qpn),   64'(e.qpn));
            check("stall_laddr", wif.wqe_laddr,      e.laddr);
            check("stall_raddr", wif.wqe_raddr,      e.raddr);
            check("stall_rkey",  64'(wif.wqe_rkey),  64'(e.rkey));
            check("stall_len",   64'(wif.wqe_len),   64'(e.len));
            RDMA_write_en = (i == 1);
            cyc(1);
        end
        RDMA_write_en = 1'b0;
        wif.wqe_ready = 1'b1;
        cyc(1);
        wif.wqe_ready = 1'b0;
    endtask

    task automatic send_cq(input logic [3:0] qpn, input logic [7:0] status);
        cyc(1);
        wif.cq_valid  = 1'b1;
        wif.cq_qpn    = qpn;
        wif.cq_status = status;
        cyc(1);
        wif.cq_valid  = 1'b0;
        wif.cq_qpn    = 4'd0;
        wif.cq_status = 8'd0;
    endtask

    task automatic do_track(input logic [3:0] qpn, input logic [63:0] laddr,
                            input logic [63:0] raddr, input logic [31:0] rkey,
                            input bit tlast, input logic [3:0] exp_cur, input int stall);
        int d0;
        int n;
        issue_accept(wqe_t'{qpn: qpn, laddr: laddr, raddr: raddr, rkey: rkey, len: 32'h1000}, stall);
        exp_tlast_q.push_back(tlast);
        d0 = done_cnt;
        send_cq(qpn, 8'd0);
        n = 0;
        while (done_cnt == d0 && n < 10) begin
            cyc(1);
            n++;
        end
        check("done_pulses", 64'(done_cnt - d0), 64'd1);
        check("cur_qpn_after", 64'(cur_qpn), 64'(exp_cur));
        cyc(2);
        check("done_pulses_settled", 64'(done_cnt - d0), 64'd1);
    endtask

    // kind 0: bad status, 1: wrong QP, 2: completion timeout
    task automatic err_case(input int kind);
        int d0;
        bit seen;
        do_reset();
        load_mr(4'd2, 64'h1000_0000, 32'h4000, 32'hAB);
        set_cfg(4'd1, 4'd1);
        issue_accept(wqe_t'{qpn: 4'd2, laddr: 64'h0, raddr: 64'h1000_0000, rkey: 32'hAB, len: 32'h1000}, 0);
        d0 = done_cnt;
        if (kind == 2) begin
            cyc(15);
            check("timeout_not_yet", 64'(wr_error), 64'd0);
            cyc(1);
            check("timeout_err", 64'(wr_error), 64'd1);
        end else begin
            send_cq((kind == 0) ? 4'd2 : 4'd3, (kind == 0) ? 8'h05 : 8'h00);
            check("cq_err", 64'(wr_error), 64'd1);
        end
        RDMA_write_en = 1'b1;
        cyc(1);
        RDMA_write_en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (wif.wqe_valid) seen = 1'b1;
            cyc(1);
        end
        check("no_wqe_in_err", 64'(seen), 64'd0);
        check("err_sticky", 64'(wr_error), 64'd1);
        check("no_done_in_err", 64'(done_cnt - d0), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        core_aresetn      = 1'b0;
        rx_MR_tvalid      = 1'b0;
        rx_MR_QPn         = 4'd0;
        host_MR_addr      = 64'd0;
        host_MR_len       = 32'd0;
        host_MR_rkey      = 32'd0;
        IMC_NUM           = 4'd0;
        track_num_per_IMC = 4'd0;
        track_len         = 32'd0;
        RDMA_write_en     = 1'b0;
        wif.wqe_ready     = 1'b0;
        wif.cq_valid      = 1'b0;
        wif.cq_qpn        = 4'd0;
        wif.cq_status     = 8'd0;
        cyc(2);

        // Reset values
        check("rst_wqe_valid", 64'(wif.wqe_valid), 64'd0);
        check("rst_wqe_qpn",   64'(wif.wqe_qpn),   64'd0);
        check("rst_wqe_laddr", wif.wqe_laddr,      64'd0);
        check("rst_wqe_raddr", wif.wqe_raddr,      64'd0);
        check("rst_wqe_rkey",  64'(wif.wqe_rkey),  64'd0);
        check("rst_wqe_len",   64'(wif.wqe_len),   64'd0);
        check("rst_done",      64'(RDMA_track_done), 64'd0);
        check("rst_tlast",     64'(track_tlast),   64'd0);
        check("rst_cur_qpn",   64'(cur_qpn),       64'd2);
        check("rst_wr_error",  64'(wr_error),      64'd0);
        core_aresetn = 1'b1;
        cyc(1);

        // Two QPs, two tracks each
        load_mr(4'd2, 64'h1000_0000, 32'h4000, 32'hAB);
        load_mr(4'd3, 64'h2000_0000, 32'h4000, 32'hCD);
        set_cfg(4'd2, 4'd2);
        do_track(4'd2, 64'h0000, 64'h1000_0000, 32'hAB, 1'b0, 4'd2, 0);
        do_track(4'd2, 64'h1000, 64'h1000_1000, 32'hAB, 1'b1, 4'd3, 0);
        do_track(4'd3, 64'h2000, 64'h2000_0000, 32'hCD, 1'b0, 4'd3, 0);
        do_track(4'd3, 64'h3000, 64'h2000_1000, 32'hCD, 1'b1, 4'd2, 0);

        // Remote offset wrap inside a 0x2000-byte MR
        load_mr(4'd2, 64'h1000_0000, 32'h2000, 32'hAB);
        set_cfg(4'd1, 4'd4);
        do_track(4'd2, 64'h4000, 64'h1000_0000, 32'hAB, 1'b0, 4'd2, 0);
        do_track(4'd2, 64'h5000, 64'h1000_1000, 32'hAB, 1'b0, 4'd2, 0);
        do_track(4'd2, 64'h6000, 64'h1000_0000, 32'hAB, 1'b0, 4'd2, 0);
        do_track(4'd2, 64'h7000, 64'h1000_1000, 32'hAB, 1'b1, 4'd2, 0);

        // wqe_ready stalled 5 cycles, write_en during ISSUE ignored
        set_cfg(4'd1, 4'd1);
        do_track(4'd2, 64'h8000, 64'h1000_0000, 32'hAB, 1'b1, 4'd2, 5);

        // Out-of-range MR QPns ignored; zero counts behave as one
        load_mr(4'd1,  64'hDEAD_0000, 32'h100, 32'hEE);
        load_mr(4'd15, 64'hBEEF_0000, 32'h100, 32'hEE);
        set_cfg(4'd0, 4'd0);
        do_track(4'd2, 64'h9000, 64'h1000_1000, 32'hAB, 1'b1, 4'd2, 0);
        do_track(4'd2, 64'hA000, 64'h1000_0000, 32'hAB, 1'b1, 4'd2, 0);

        // Reset while waiting for the completion
        issue_accept(wqe_t'{qpn: 4'd2, laddr: 64'hB000, raddr: 64'h1000_1000, rkey: 32'hAB, len: 32'h1000}, 0);
        cyc(2);
        core_aresetn = 1'b0;
        cyc(1);
        check("midrst_wqe_valid", 64'(wif.wqe_valid), 64'd0);
        check("midrst_cur_qpn",   64'(cur_qpn),       64'd2);
        check("midrst_wr_error",  64'(wr_error),      64'd0);
        check("midrst_done",      64'(RDMA_track_done), 64'd0);
        core_aresetn = 1'b1;
        cyc(1);
        load_mr(4'd2, 64'h1000_0000, 32'h4000, 32'hAB);
        set_cfg(4'd2, 4'd2);
        do_track(4'd2, 64'h0000, 64'h1000_0000, 32'hAB, 1'b0, 4'd2, 0);

        // Error paths
        err_case(0);
        err_case(1);
        err_case(2);

        check("wqe_queue_drained",  64'(exp_wqe_q.size()),   64'd0);
        check("done_queue_drained", 64'(exp_tlast_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rdma_track_wr_sched.md
Name: rdma_track_wr_sched

Overview:
- Sits directly downstream of the RDMA connection FSM.
- Stores the host memory-region (MR) descriptors received per QP.
- On each RDMA_write_en pulse, selects the current QP and issues one RDMA WRITE work request for one track, sized to the track length, to the ERNIC WQE interface.
- Waits for that request's completion, then pulses RDMA_track_done back to the FSM, which issues the next write.

Parameters:
- QP_NUM, 9, number of QPs including QP1; data QPs are 2..QP_NUM-1, table depth QP_NUM-1.
- LOCAL_BASE, 64'h0, DDR byte address of the first track buffer.
- LOCAL_SIZE, 32'h4000_0000, byte size of the local ring; the local address wraps inside it.
- CQ_TIMEOUT, 24'hFF_FFFF, core_clk cycles allowed between WQE acceptance and completion.

Ports:
- core_clk input 1 clock
- core_aresetn input 1 asynchronous active-low reset
- rx_MR_tvalid input 1 MR descriptor strobe, one cycle
- rx_MR_QPn input 4 QP number of the descriptor
- host_MR_addr input 64 host buffer base address
- host_MR_len input 32 host buffer byte length
- host_MR_rkey input 32 host buffer rkey
- IMC_NUM input 4 number of active QPs/IMCs
- track_num_per_IMC input 4 tracks written to one QP before advancing to the next QP
- track_len input 32 bytes per track, multiple of 64
- RDMA_write_en input 1 one-cycle request to write one track
- wqe_valid output 1 WQE valid
- wqe_ready input 1 WQE accepted
- wqe_qpn output 4 target QP
- wqe_laddr output 64 local DDR source address
- wqe_raddr output 64 remote address
- wqe_rkey output 32 remote key
- wqe_len output 32 byte length
- cq_valid input 1 completion strobe
- cq_qpn input 4 completion QP
- cq_status input 8 completion status; 0 means OK
- RDMA_track_done output 1 one-cycle pulse per completed track
- track_tlast output 1 one-cycle pulse, coincident with RDMA_track_done, on the last track of a QP
- cur_qpn output 4 QP that will receive the next write
- wr_error output 1 sticky error flag

Behaviour:
- Clock is core_clk. Reset is core_aresetn, asynchronous, active-low.
- Reset values:
  - All outputs 0, except cur_qpn=2.
  - MR table cleared; per-QP remote offsets 0; local offset 0; counters 0.
- MR table:
  - Write entry [rx_MR_QPn-2] with addr, len and rkey when rx_MR_tvalid and 2<=rx_MR_QPn<=QP_NUM-1.
  - A QPn outside that range is ignored.
  - A write also clears that entry's remote offset to 0.
  - The table is writable in any state, including an in-flight WQE: the latched WQE fields do not change; the new values apply to the next issue.
- Effective counts: imc_eff = max(IMC_NUM,1); tpi_eff = max(track_num_per_IMC,1).
- States: IDLE, ISSUE, WAIT_CQ, DONE, ERR.
  - IDLE: on RDMA_write_en, latch all wqe_* fields from the current QP entry and offsets -> ISSUE (next cycle).
  - ISSUE: wqe_valid=1, fields held stable; on wqe_ready -> WAIT_CQ and start the timeout counter.
  - WAIT_CQ:
    - cq_valid with cq_qpn==wqe_qpn and cq_status==0 -> DONE.
    - cq_valid with a mismatched QP or nonzero status -> ERR.
    - Timeout counter reaching CQ_TIMEOUT -> ERR.
  - DONE (one cycle): pulse RDMA_track_done; update counters and offsets -> IDLE.
  - ERR: wr_error=1; no further WQEs; stays in ERR until reset.
- RDMA_write_en outside IDLE is ignored; no queuing.
- Address arithmetic:
  - wqe_raddr = host_MR_addr + remote_offset[qp]; wqe_laddr = LOCAL_BASE + local_offset; wqe_len = track_len.
  - In DONE: if remote_offset + 2*track_len > host_MR_len, remote_offset := 0; otherwise remote_offset += track_len. The same rule applies to local_offset against LOCAL_SIZE.
  - Additions are 64-bit unsigned; comparisons are unsigned.
- Sequencing, in DONE:
  - If track_cnt == tpi_eff-1: track_cnt := 0, pulse track_tlast, and advance the QP index (cur_qpn := cur_qpn+1, wrapping to 2 after 2+imc_eff-1).
  - Otherwise track_cnt += 1.
- A stale cq_valid in IDLE or ISSUE is ignored.
- Reset mid-operation: immediate return to reset values; any WQE in flight is abandoned.

Test Plan:
- MR for QP2 (addr 0x1000_0000, len 0x4000, rkey 0xAB) and QP3 (addr 0x2000_0000); IMC_NUM=2, track_num_per_IMC=2, track_len=0x1000; four write_en/cq cycles -> WQE sequence QP2@0x1000_0000, QP2@0x1000_1000, QP3@0x2000_0000, QP3@0x2000_1000; track_tlast on the 2nd and 4th done pulses; cur_qpn returns to 2.
- QP2 len 0x2000, track_len 0x1000, tpi=4 -> raddr 0x1000_0000, 0x1000_1000, 0x1000_0000, 0x1000_1000 (wrap).
- wqe_ready held low 5 cycles -> wqe_valid and all fields stable for those 5 cycles; RDMA_write_en pulsed during ISSUE is ignored, and exactly one done pulse follows.
- cq_status=0x05 -> wr_error=1, state ERR, a later RDMA_write_en produces no wqe_valid; wrong cq_qpn gives the same result; CQ_TIMEOUT=16 with no completion -> wr_error at 16 cycles after acceptance.
- IMC_NUM=0, track_num_per_IMC=0 -> every track goes to QP2 and every done pulse carries track_tlast; rx_MR_QPn=1 or 15 -> table unchanged.
- Assert reset during WAIT_CQ -> wqe_valid=0, cur_qpn=2, offsets 0; a normal first write afterwards uses the cleared offsets.
